pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 16-bit 5-stage MIPS pipeline.
- Watches the ID and EX stages and the memory and IN-port handshakes.
- Drives write-enables and flushes (bubble insertion) for PC, IF/ID, ID/EX and EX/MEM.
- Sequences load-use stalls, IN-port waits, data-memory wait states and taken-branch squashes.
- Keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/sat_counter.sv | 24 ++
 rtl/pipe_hazard_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// default widths and the all-zero control word the pipeline registers load
// when a bubble is inserted.
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      IO_WAIT  = 2'd2
   } state_t;

   localparam int RA_W_DEF = 3;
   localparam int CNT_W_DEF = 16;

   // Width of the control bundle carried through ID/EX and EX/MEM.
   localparam int CTRL_W = 8;
   localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear. Sticks at all-ones instead
// of wrapping so a long stall never reads back as a short one.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   // Clear wins over increment; increment stops at the all-ones value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline. Detects load-use
// and IN-port hazards, squashes wrong-path instructions on taken branches,
// freezes everything while data memory is busy and counts stall cycles.
module pipe_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int RA_W       = RA_W_DEF,
   parameter int LU_BUBBLES = 1,
   parameter int R0_ZERO    = 1,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [RA_W-1:0]  id_rs,
   input  logic [RA_W-1:0]  id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             ex_mem_read,
   input  logic [RA_W-1:0]  ex_dst,
   input  logic             ex_branch_taken,
   input  logic             ex_in,
   input  logic             in_valid,
   output logic             in_ack,
   input  logic             mem_busy,
   input  logic             cnt_clr,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             exmem_en,
   output logic             exmem_flush,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt
);

   state_t     state_q;
   state_t     state_nxt;
   logic [2:0] bub_q;
   logic [2:0] bub_nxt;
   logic       lu_raw;
   logic       lu;
   logic       iow;

   // Hazard detection: a load in EX whose destination is read by ID, unless
   // the destination is the hard-wired zero register; IN waits on the port.
   always_comb begin
      lu_raw = ex_mem_read &&
               ((id_use_rs && (id_rs == ex_dst)) ||
                (id_use_rt && (id_rt == ex_dst)));
      lu     = lu_raw && !((R0_ZERO != 0) && (ex_dst == '0));
      iow    = ex_in && !in_valid;
   end

   // State and remaining-bubble registers; reset drops any pending stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         bub_q   <= 3'd0;
      end else begin
         state_q <= state_nxt;
         bub_q   <= bub_nxt;
      end
   end

   // Next-state and pipeline-control decode; mem_busy freezes everything,
   // then IN wait, then branch squash, then load-use.
   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_en     = 1'b1;
      idex_flush  = 1'b0;
      exmem_en    = 1'b1;
      exmem_flush = 1'b0;
      in_ack      = 1'b0;
      state_nxt   = state_q;
      bub_nxt     = bub_q;

      if (rst) begin
         pc_en     = 1'b0;
         ifid_en   = 1'b0;
         idex_en   = 1'b0;
         exmem_en  = 1'b0;
         state_nxt = RUN;
         bub_nxt   = 3'd0;
      end else if (mem_busy) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_en  = 1'b0;
         exmem_en = 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (iow) begin
                  pc_en       = 1'b0;
                  ifid_en     = 1'b0;
                  idex_en     = 1'b0;
                  exmem_flush = 1'b1;
                  state_nxt   = IO_WAIT;
               end else if (ex_branch_taken) begin
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
               end else if (lu) begin
                  pc_en      = 1'b0;
                  ifid_en    = 1'b0;
                  idex_flush = 1'b1;
                  if (LU_BUBBLES > 1) begin
                     state_nxt = LU_STALL;
                     bub_nxt   = 3'(LU_BUBBLES - 1);
                  end
               end
               if (ex_in && in_valid) begin
                  in_ack = 1'b1;
               end
            end
            LU_STALL: begin
               if (ex_branch_taken) begin
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
                  state_nxt  = RUN;
                  bub_nxt    = 3'd0;
               end else begin
                  pc_en      = 1'b0;
                  ifid_en    = 1'b0;
                  idex_flush = 1'b1;
                  if (bub_q <= 3'd1) begin
                     state_nxt = RUN;
                     bub_nxt   = 3'd0;
                  end else begin
                     bub_nxt = bub_q - 3'd1;
                  end
               end
            end
            IO_WAIT: begin
               if (!in_valid) begin
                  pc_en       = 1'b0;
                  ifid_en     = 1'b0;
                  idex_en     = 1'b0;
                  exmem_flush = 1'b1;
               end else begin
                  in_ack    = 1'b1;
                  state_nxt = RUN;
               end
            end
            default: begin
               state_nxt = RUN;
               bub_nxt   = 3'd0;
            end
         endcase
      end
   end

   assign state = state_q;

   sat_counter #(
      .W(CNT_W)
   ) u_stall_cnt (
      .clk(clk),
      .rst(rst),
      .clr(cnt_clr),
      .inc(!pc_en),
      .cnt(stall_cnt)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl. Three instances share the same
// stimulus: A (1 bubble, 4-bit counter), B (2 bubbles), C (3 bubbles).
// Control outputs are packed as {pc_en, ifid_en, ifid_flush, idex_en,
// idex_flush, exmem_en, exmem_flush, in_ack} and compared to fixed patterns.
module tb_pipe_hazard_ctrl;

   localparam logic [7:0] P_NORM = 8'b11010100;
   localparam logic [7:0] P_ZERO = 8'b00000000;
   localparam logic [7:0] P_LU   = 8'b00011100;
   localparam logic [7:0] P_BR   = 8'b11111100;
   localparam logic [7:0] P_IOW  = 8'b00000110;
   localparam logic [7:0] P_ACK  = 8'b11010101;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] id_rs, id_rt, ex_dst;
   logic       id_use_rs, id_use_rt, ex_mem_read, ex_branch_taken;
   logic       ex_in, in_valid, mem_busy, cnt_clr;

   logic a_pc_en, a_ifid_en, a_ifid_flush, a_idex_en, a_idex_flush, a_exmem_en, a_exmem_flush, a_in_ack;
   logic b_pc_en, b_ifid_en, b_ifid_flush, b_idex_en, b_idex_flush, b_exmem_en, b_exmem_flush, b_in_ack;
   logic c_pc_en, c_ifid_en, c_ifid_flush, c_idex_en, c_idex_flush, c_exmem_en, c_exmem_flush, c_in_ack;
   logic [1:0]  a_state, b_state, c_state;
   logic [3:0]  a_cnt;
   logic [15:0] b_cnt, c_cnt;
   logic [7:0]  a_ctl, b_ctl, c_ctl;

   int vectors = 0;
   int miscompares = 0;

   assign a_ctl = {a_pc_en, a_ifid_en, a_ifid_flush, a_idex_en, a_idex_flush, a_exmem_en, a_exmem_flush, a_in_ack};
   assign b_ctl = {b_pc_en, b_ifid_en, b_ifid_flush, b_idex_en, b_idex_flush, b_exmem_en, b_exmem_flush, b_in_ack};
   assign c_ctl = {c_pc_en, c_ifid_en, c_ifid_flush, c_idex_en, c_idex_flush, c_exmem_en, c_exmem_flush, c_in_ack};

   // Free-running pipeline clock, 10 time-unit period.
   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.RA_W(3), .LU_BUBBLES(1), .R0_ZERO(1), .CNT_W(4)) dut_a (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .ex_mem_read(ex_mem_read), .ex_dst(ex_dst), .ex_branch_taken(ex_branch_taken), .ex_in(ex_in),
      .in_valid(in_valid), .in_ack(a_in_ack), .mem_busy(mem_busy), .cnt_clr(cnt_clr),
      .pc_en(a_pc_en), .ifid_en(a_ifid_en), .ifid_flush(a_ifid_flush), .idex_en(a_idex_en),
      .idex_flush(a_idex_flush), .exmem_en(a_exmem_en), .exmem_flush(a_exmem_flush),
      .state(a_state), .stall_cnt(a_cnt));

   pipe_hazard_ctrl #(.RA_W(3), .LU_BUBBLES(2), .R0_ZERO(1), .CNT_W(16)) dut_b (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .ex_mem_read(ex_mem_read), .ex_dst(ex_dst), .ex_branch_taken(ex_branch_taken), .ex_in(ex_in),
      .in_valid(in_valid), .in_ack(b_in_ack), .mem_busy(mem_busy), .cnt_clr(cnt_clr),
      .pc_en(b_pc_en), .ifid_en(b_ifid_en), .ifid_flush(b_ifid_flush), .idex_en(b_idex_en),
      .idex_flush(b_idex_flush), .exmem_en(b_exmem_en), .exmem_flush(b_exmem_flush),
      .state(b_state), .stall_cnt(b_cnt));

   pipe_hazard_ctrl #(.RA_W(3), .LU_BUBBLES(3), .R0_ZERO(1), .CNT_W(16)) dut_c (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .ex_mem_read(ex_mem_read), .ex_dst(ex_dst), .ex_branch_taken(ex_branch_taken), .ex_in(ex_in),
      .in_valid(in_valid), .in_ack(c_in_ack), .mem_busy(mem_busy), .cnt_clr(cnt_clr),
      .pc_en(c_pc_en), .ifid_en(c_ifid_en), .ifid_flush(c_ifid_flush), .idex_en(c_idex_en),
      .idex_flush(c_idex_flush), .exmem_en(c_exmem_en), .exmem_flush(c_exmem_flush),
      .state(c_state), .stall_cnt(c_cnt));

   task automatic clear_inputs();
      id_rs = 3'd0; id_rt = 3'd0; ex_dst = 3'd0;
      id_use_rs = 1'b0; id_use_rt = 1'b0; ex_mem_read = 1'b0;
      ex_branch_taken = 1'b0; ex_in = 1'b0; in_valid = 1'b0;
      mem_busy = 1'b0; cnt_clr = 1'b0;
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      clear_inputs();
      tick();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      #1;
   endtask

   task automatic set_lu_rs3();
      ex_mem_read = 1'b1; ex_dst = 3'd3; id_rs = 3'd3; id_use_rs = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      tick();
      rst = 1'b1;
      #1;
      vectors++;
      if (a_ctl !== P_ZERO) begin miscompares++; $display("[TB] FAIL reset_ctl got %b want %b", a_ctl, P_ZERO); end
      vectors++;
      if (a_state !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_state got %0d want 0", a_state); end
      vectors++;
      if (a_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_cnt got %0d want 0", a_cnt); end
      #1;
      rst = 1'b0;
      #1;
      vectors++;
      if (a_ctl !== P_NORM) begin miscompares++; $display("[TB] FAIL idle_ctl got %b want %b", a_ctl, P_NORM); end
   endtask

   task automatic test_load_use();
      pulse_reset();
      set_lu_rs3();
      #1;
      vectors++;
      if (a_ctl !== P_LU) begin miscompares++; $display("[TB] FAIL lu1_ctl got %b want %b", a_ctl, P_LU); end
      tick();
      vectors++;
      if (a_state !== 2'd0) begin miscompares++; $display("[TB] FAIL lu1_state got %0d want 0", a_state); end
      vectors++;
      if (a_cnt !== 4'd1) begin miscompares++; $display("[TB] FAIL lu1_cnt got %0d want 1", a_cnt); end
      clear_inputs();
      #1;
      vectors++;
      if (a_ctl !== P_NORM) begin miscompares++; $display("[TB] FAIL lu1_after_ctl got %b want %b", a_ctl, P_NORM); end
      tick();
      vectors++;
      if (a_cnt !== 4'd1) begin miscompares++; $display("[TB] FAIL lu1_after_cnt got %0d want 1", a_cnt); end
   endtask

   task automatic test_r0_mask();
      pulse_reset();
      ex_mem_read = 1'b1; ex_dst = 3'd0; id_rs = 3'd0; id_use_rs = 1'b1;
      #1;
      vectors++;
      if (b_ctl !== P_NORM) begin miscompares++; $display("[TB] FAIL r0_ctl got %b want %b", b_ctl, P_NORM); end
      ex_dst = 3'd5; id_rs = 3'd5; id_use_rs = 1'b0; id_rt = 3'd2; id_use_rt = 1'b1;
      #1;
      vectors++;
      if (b_ctl !== P_NORM) begin miscompares++; $display("[TB] FAIL unused_rs_ctl got %b want %b", b_ctl, P_NORM); end
      tick();
      vectors++;
      if (b_cnt !== 16'd0) begin miscompares++; $display("[TB] FAIL r0_cnt got %0d want 0", b_cnt); end
      id_rs = 3'd1; id_rt = 3'd5;
      #1;
      vectors++;
      if (b_ctl !== P_LU) begin miscompares++; $display("[TB] FAIL lu2_first_ctl got %b want %b", b_ctl, P_LU); end
      tick();
      vectors++;
      if (b_state !== 2'd1) begin miscompares++; $display("[TB] FAIL lu2_state1 got %0d want 1", b_state); end
      clear_inputs();
      #1;
      vectors++;
      if (b_ctl !== P_LU) begin miscompares++; $display("[TB] FAIL lu2_second_ctl got %b want %b", b_ctl, P_LU); end
      tick();
      vectors++;
      if (b_state !== 2'd0) begin miscompares++; $display("[TB] FAIL lu2_state0 got %0d want 0", b_state); end
      vectors++;
      if (b_cnt !== 16'd2) begin miscompares++; $display("[TB] FAIL lu2_cnt got %0d want 2", b_cnt); end
      vectors++;
      if (b_ctl !== P_NORM) begin miscompares++; $display("[TB] FAIL lu2_done_ctl got %b want %b", b_ctl, P_NORM); end
   endtask

   task automatic test_branch_vs_lu();
      pulse_reset();
      set_lu_rs3();
      ex_branch_taken = 1'b1;
      #1;
      vectors++;
      if (a_ctl !== P_BR) begin miscompares++; $display("[TB] FAIL br_lu_ctl got %b want %b", a_ctl, P_BR); end
      tick();
      vectors++;
      if (a_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL br_lu_cnt got %0d want 0", a_cnt); end
      vectors++;
      if (c_state !== 2'd0) begin miscompares++; $display("[TB] FAIL br_lu_state got %0d want 0", c_state); end
   endtask

   task automatic test_in_wait();
      pulse_reset();
      ex_in = 1'b1; in_valid = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         #1;
         vectors++;
         if (a_ctl !== P_IOW) begin miscompares++; $display("[TB] FAIL iow_ctl cycle %0d got %b want %b", i, a_ctl, P_IOW); end
         tick();
         vectors++;
         if (a_state !== 2'd2) begin miscompares++; $display("[TB] FAIL iow_state cycle %0d got %0d want 2", i, a_state); end
      end
      in_valid = 1'b1;
      #1;
      vectors++;
      if (a_ctl !== P_ACK) begin miscompares++; $display("[TB] FAIL iow_ack_ctl got %b want %b", a_ctl, P_ACK); end
      tick();
      vectors++;
      if (a_state !== 2'd0) begin miscompares++; $display("[TB] FAIL iow_exit_state got %0d want 0", a_state); end
      vectors++;
      if (a_cnt !== 4'd3) begin miscompares++; $display("[TB] FAIL iow_cnt got %0d want 3", a_cnt); end
      ex_in = 1'b0;
      #1;
      vectors++;
      if (a_ctl !== P_NORM) begin miscompares++; $display("[TB] FAIL iow_single_ack got %b want %b", a_ctl, P_NORM); end
   endtask

   task automatic test_lu_with_iow();
      pulse_reset();
      set_lu_rs3();
      ex_in = 1'b1;
      #1;
      vectors++;
      if (a_ctl !== P_IOW) begin miscompares++; $display("[TB] FAIL lu_iow_ctl got %b want %b", a_ctl, P_IOW); end
      mem_busy = 1'b1;
      #1;
      vectors++;
      if (a_ctl !== P_ZERO) begin miscompares++; $display("[TB] FAIL busy_over_iow got %b want %b", a_ctl, P_ZERO); end
      tick();
      vectors++;
      if (a_state !== 2'd0) begin miscompares++; $display("[TB] FAIL busy_hold_state got %0d want 0", a_state); end
   endtask

   task automatic test_mem_busy_stall();
      pulse_reset();
      set_lu_rs3();
      #1;
      vectors++;
      if (c_ctl !== P_LU) begin miscompares++; $display("[TB] FAIL lu3_first_ctl got %b want %b", c_ctl, P_LU); end
      tick();
      clear_inputs();
      mem_busy = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         #1;
         vectors++;
         if (c_ctl !== P_ZERO) begin miscompares++; $display("[TB] FAIL busy_ctl cycle %0d got %b want %b", i, c_ctl, P_ZERO); end
         tick();
         vectors++;
         if (c_state !== 2'd1) begin miscompares++; $display("[TB] FAIL busy_state cycle %0d got %0d want 1", i, c_state); end
      end
      vectors++;
      if (c_cnt !== 16'd5) begin miscompares++; $display("[TB] FAIL busy_cnt got %0d want 5", c_cnt); end
      mem_busy = 1'b0;
      #1;
      vectors++;
      if (c_ctl !== P_LU) begin miscompares++; $display("[TB] FAIL lu3_second_ctl got %b want %b", c_ctl, P_LU); end
      tick();
      vectors++;
      if (c_state !== 2'd1) begin miscompares++; $display("[TB] FAIL lu3_mid_state got %0d want 1", c_state); end
      vectors++;
      if (c_ctl !== P_LU) begin miscompares++; $display("[TB] FAIL lu3_third_ctl got %b want %b", c_ctl, P_LU); end
      tick();
      vectors++;
      if (c_state !== 2'd0) begin miscompares++; $display("[TB] FAIL lu3_end_state got %0d want 0", c_state); end
      vectors++;
      if (c_cnt !== 16'd7) begin miscompares++; $display("[TB] FAIL lu3_cnt got %0d want 7", c_cnt); end
      vectors++;
      if (c_ctl !== P_NORM) begin miscompares++; $display("[TB] FAIL lu3_done_ctl got %b want %b", c_ctl, P_NORM); end
      // Taken branch while still holding bubbles squashes and returns to RUN.
      set_lu_rs3();
      tick();
      clear_inputs();
      ex_branch_taken = 1'b1;
      #1;
      vectors++;
      if (c_ctl !== P_BR) begin miscompares++; $display("[TB] FAIL stall_branch_ctl got %b want %b", c_ctl, P_BR); end
      tick();
      vectors++;
      if (c_state !== 2'd0) begin miscompares++; $display("[TB] FAIL stall_branch_state got %0d want 0", c_state); end
      vectors++;
      if (c_cnt !== 16'd8) begin miscompares++; $display("[TB] FAIL stall_branch_cnt got %0d want 8", c_cnt); end
   endtask

   task automatic test_reset_mid_io();
      pulse_reset();
      ex_in = 1'b1;
      tick();
      tick();
      vectors++;
      if (a_state !== 2'd2) begin miscompares++; $display("[TB] FAIL pre_reset_state got %0d want 2", a_state); end
      rst = 1'b1;
      #1;
      vectors++;
      if (a_ctl !== P_ZERO) begin miscompares++; $display("[TB] FAIL mid_reset_ctl got %b want %b", a_ctl, P_ZERO); end
      vectors++;
      if (a_state !== 2'd0) begin miscompares++; $display("[TB] FAIL mid_reset_state got %0d want 0", a_state); end
      vectors++;
      if (a_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL mid_reset_cnt got %0d want 0", a_cnt); end
      clear_inputs();
      rst = 1'b0;
      #1;
      vectors++;
      if (a_ctl !== P_NORM) begin miscompares++; $display("[TB] FAIL post_reset_ctl got %b want %b", a_ctl, P_NORM); end
   endtask

   task automatic test_saturation();
      pulse_reset();
      mem_busy = 1'b1;
      for (int i = 0; i < 14; i++) tick();
      vectors++;
      if (a_cnt !== 4'd14) begin miscompares++; $display("[TB] FAIL sat_14 got %0d want 14", a_cnt); end
      for (int i = 0; i < 6; i++) tick();
      vectors++;
      if (a_cnt !== 4'd15) begin miscompares++; $display("[TB] FAIL sat_20 got %0d want 15", a_cnt); end
      vectors++;
      if (b_cnt !== 16'd20) begin miscompares++; $display("[TB] FAIL wide_20 got %0d want 20", b_cnt); end
      cnt_clr = 1'b1;
      tick();
      vectors++;
      if (a_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL clr_cnt got %0d want 0", a_cnt); end
      cnt_clr = 1'b0;
      mem_busy = 1'b0;
      tick();
      vectors++;
      if (a_cnt !== 4'd0) begin miscompares++; $display("[TB] FAIL clr_hold got %0d want 0", a_cnt); end
   endtask

   // Run every scenario in order, then report.
   initial begin
      clear_inputs();
      test_reset();
      test_load_use();
      test_r0_mask();
      test_branch_vs_lu();
      test_in_wait();
      test_lu_with_iow();
      test_mem_busy_stall();
      test_reset_mid_io();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
